// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I base opcodes, decoded-format encoding and opcode-to-format lookup.
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;
  // Every supported opcode ends in 2'b11, so a compressed/invalid low pair falls to ILL.
  function automatic logic [2:0] op_fmt(input logic [6:0] op);
    return op == OP_R ? FMT_R :
           (op == OP_IMM || op == OP_LOAD || op == OP_JALR || op == OP_SYSTEM) ? FMT_I :
           op == OP_STORE ? FMT_S :
           op == OP_BRANCH ? FMT_B :
           (op == OP_LUI || op == OP_AUIPC) ? FMT_U :
           op == OP_JAL ? FMT_J : FMT_ILL;
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational sign-extended immediate for a given instruction format.
module imm_gen import riscv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      fmt,
  output logic [XLEN-1:0] o_imm
);
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];
  always_comb
    o_imm = fmt == FMT_I ? {{20{instr[31]}}, instr[31:20]} :
            fmt == FMT_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
            fmt == FMT_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
            fmt == FMT_U ? {instr[31:12], 12'b0} :
            fmt == FMT_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
            '0;
endmodule

// File: rtl/instr_queue_deco.sv
// instr_queue_deco: DEPTH-entry instruction queue with flush, decoding the head entry.
module instr_queue_deco import riscv_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic            clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [PC_W-1:0] o_pc,
  output logic [6:0]      o_opcode,
  output logic [2:0]      o_funct3,
  output logic [6:0]      o_funct7,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [2:0]      o_fmt,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal,
  output logic [CW-1:0]   o_count
);
  logic [31:0]     instr_q [DEPTH];
  logic [31:0]     instr_d [DEPTH];
  logic [PC_W-1:0] pc_q [DEPTH];
  logic [PC_W-1:0] pc_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;
  logic [31:0]     inst;
  logic [2:0]      fmt_raw;
  assign o_ready = !i_rst && count_q < CW'(DEPTH);
  assign o_valid = count_q != '0;
  assign o_count = count_q;
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    if (push) begin
      instr_d[wr_ptr_q] = i_instr;
      pc_d[wr_ptr_q]    = i_pc;
    end
    wr_ptr_d = i_flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = i_flush ? '0 : rd_ptr_q + AW'(pop);
    count_d  = i_flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // Storage is deliberately left out of reset; only pointers and count are cleared.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
  end
  always_comb begin
    inst      = o_valid ? instr_q[rd_ptr_q] : '0;
    fmt_raw   = op_fmt(inst[6:0]);
    o_fmt     = o_valid ? fmt_raw : FMT_ILL;
    o_illegal = o_valid && fmt_raw == FMT_ILL;
    o_pc      = o_valid ? pc_q[rd_ptr_q] : '0;
    o_opcode  = inst[6:0];
    o_rd      = inst[11:7];
    o_funct3  = inst[14:12];
    o_rs1     = inst[19:15];
    o_rs2     = inst[24:20];
    o_funct7  = inst[31:25];
  end
  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (inst),
    .fmt   (o_fmt),
    .o_imm (o_imm)
  );
endmodule

// File: tb/tb_instr_queue_deco.sv
// tb_instr_queue_deco: directed and randomized checks against a queue-based reference model.
module tb_instr_queue_deco;
  localparam int DEPTH = 4;
  logic        clk = 0;
  logic        i_rst = 1, i_valid = 0, i_ready = 0, i_flush = 0;
  logic [31:0] i_instr = 0, i_pc = 0;
  logic        o_ready, o_valid, o_illegal;
  logic [31:0] o_pc, o_imm;
  logic [6:0]  o_opcode, o_funct7;
  logic [2:0]  o_funct3, o_fmt;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic [2:0]  o_count;
  int          n_tests = 0, n_fail = 0;
  typedef struct {logic [31:0] w; logic [31:0] p;} ent_t;
  ent_t        q[$];

  always #5 clk = ~clk;

  instr_queue_deco #(.XLEN(32), .PC_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_instr(i_instr),
    .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
    .o_opcode(o_opcode), .o_funct3(o_funct3), .o_funct7(o_funct7), .o_rd(o_rd),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_fmt(o_fmt), .o_imm(o_imm), .o_illegal(o_illegal),
    .o_count(o_count)
  );

  function automatic logic [2:0] ref_fmt(input logic [31:0] w);
    case (w[6:0])
      7'h33:                      return 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73: return 3'd1;
      7'h23:                      return 3'd2;
      7'h63:                      return 3'd3;
      7'h37, 7'h17:               return 3'd4;
      7'h6F:                      return 3'd5;
      default:                    return 3'd7;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int s;
    s = int'(w[31]);
    case (ref_fmt(w))
      3'd1: return 32'(-2048 * s + int'(w[30:20]));
      3'd2: return 32'(-2048 * s + int'(w[30:25]) * 32 + int'(w[11:7]));
      3'd3: return 32'(-4096 * s + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
      3'd4: return w & 32'hFFFF_F000;
      3'd5: return 32'(-1048576 * s + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] op;
    case ($urandom_range(0, 11))
      0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h67;
      4: op = 7'h73;  5: op = 7'h23;  6: op = 7'h63;  7: op = 7'h37;
      8: op = 7'h17;  9: op = 7'h6F;  default: op = 7'($urandom);
    endcase
    return {25'($urandom), op};
  endfunction

  // One clock: drive inputs, advance the model by the queue rules, settle past the edge.
  task automatic cyc(input logic v, input logic [31:0] w, input logic [31:0] p,
                     input logic r, input logic f, input logic rs);
    logic push, pop;
    i_valid = v; i_instr = w; i_pc = p; i_ready = r; i_flush = f; i_rst = rs;
    push = v && !rs && q.size() < DEPTH;
    pop  = q.size() != 0 && r;
    @(posedge clk);
    #1;
    if (rs || f) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{w, p});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) cyc(0, 0, 0, 1, 0, 0);
    n_tests++;
    if (o_count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", o_count); end
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    n_tests++;
    if ({o_valid, o_ready, o_count, o_fmt, o_illegal, o_imm, o_pc} !== {1'b0, 1'b0, 3'd0, 3'd7, 1'b0, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%b c=%0d fmt=%0d ill=%b imm=%h pc=%h want v=0 r=0 c=0 fmt=7 ill=0 imm=0 pc=0",
               o_valid, o_ready, o_count, o_fmt, o_illegal, o_imm, o_pc);
    end
    i_rst = 0;
    #1;
    n_tests++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", o_ready); end
  endtask

  task automatic test_decode();
    cyc(1, 32'h0050_0093, 32'h100, 0, 0, 0);
    n_tests++;
    if ({o_valid, o_fmt, o_rd, o_rs1, o_imm, o_pc} !== {1'b1, 3'd1, 5'd1, 5'd0, 32'h5, 32'h100}) begin
      n_fail++;
      $display("FAIL decode_addi: got v=%b fmt=%0d rd=%0d rs1=%0d imm=%h pc=%h want v=1 fmt=1 rd=1 rs1=0 imm=00000005 pc=00000100",
               o_valid, o_fmt, o_rd, o_rs1, o_imm, o_pc);
    end
    cyc(1, 32'hFE00_0EE3, 32'h104, 1, 0, 0);
    n_tests++;
    if ({o_fmt, o_imm, o_pc} !== {3'd3, 32'hFFFF_FFFC, 32'h104}) begin
      n_fail++;
      $display("FAIL decode_beq: got fmt=%0d imm=%h pc=%h want fmt=3 imm=fffffffc pc=00000104", o_fmt, o_imm, o_pc);
    end
    cyc(1, 32'h1234_52B7, 32'h108, 1, 0, 0);
    n_tests++;
    if ({o_fmt, o_rd, o_imm} !== {3'd4, 5'd5, 32'h1234_5000}) begin
      n_fail++;
      $display("FAIL decode_lui: got fmt=%0d rd=%0d imm=%h want fmt=4 rd=5 imm=12345000", o_fmt, o_rd, o_imm);
    end
    drain();
  endtask

  task automatic test_full_and_wrap();
    for (int i = 0; i < 5; i++) begin
      cyc(1, rand_instr(), 32'h200 + 4 * i, 0, 0, 0);
      if (i == 3) begin
        n_tests++;
        if (o_ready !== 1'b0 || o_count !== 3'd4) begin
          n_fail++;
          $display("FAIL full_after_4: got ready=%b count=%0d want ready=0 count=4", o_ready, o_count);
        end
      end
    end
    n_tests++;
    if (o_count !== 3'd4 || o_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL full_reject_5th: got count=%0d pc=%h want count=4 pc=00000200", o_count, o_pc);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1, rand_instr(), 32'h300 + 4 * i, 1, 0, 0);
      n_tests++;
      if ({o_funct7, o_rs2, o_rs1, o_funct3, o_rd, o_opcode} !== q[0].w || o_pc !== q[0].p ||
          o_count !== 3'(q.size()) || (i > 0 && o_count !== 3'd3)) begin
        n_fail++;
        $display("FAIL wrap_order[%0d]: got word=%h pc=%h count=%0d want word=%h pc=%h count=%0d", i,
                 {o_funct7, o_rs2, o_rs1, o_funct3, o_rd, o_opcode}, o_pc, o_count, q[0].w, q[0].p, q.size());
      end
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) cyc(1, rand_instr(), 32'h400 + 4 * i, 0, 0, 0);
    cyc(1, 32'h0050_0093, 32'h4F0, 1, 1, 0);
    n_tests++;
    if (o_count !== 3'd0 || o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state: got count=%0d valid=%b ready=%b want count=0 valid=0 ready=1", o_count, o_valid, o_ready);
    end
    cyc(1, 32'h1234_52B7, 32'h500, 0, 0, 0);
    n_tests++;
    if (o_pc !== 32'h500 || o_count !== 3'd1) begin
      n_fail++;
      $display("FAIL flush_then_push: got pc=%h count=%0d want pc=00000500 count=1", o_pc, o_count);
    end
    drain();
  endtask

  task automatic test_illegal();
    cyc(1, 32'h0000_0000, 32'h600, 0, 0, 0);
    cyc(1, 32'h0000_007F, 32'h604, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({o_illegal, o_fmt, o_imm, o_pc} !== {1'b1, 3'd7, 32'd0, 32'h600 + 32'(4 * i)}) begin
        n_fail++;
        $display("FAIL illegal[%0d]: got ill=%b fmt=%0d imm=%h pc=%h want ill=1 fmt=7 imm=0 pc=%h",
                 i, o_illegal, o_fmt, o_imm, o_pc, 32'h600 + 32'(4 * i));
      end
      cyc(0, 0, 0, 1, 0, 0);
    end
  endtask

  task automatic test_mid_reset();
    cyc(1, rand_instr(), 32'h700, 0, 0, 0);
    cyc(1, rand_instr(), 32'h704, 0, 0, 0);
    i_rst = 1;
    #1;
    n_tests++;
    if (o_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 0", o_ready); end
    cyc(0, 0, 0, 0, 0, 1);
    n_tests++;
    if (o_count !== 3'd0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got count=%0d valid=%b want count=0 valid=0", o_count, o_valid);
    end
    i_rst = 0;
    #1;
    n_tests++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_release: got %b want 1", o_ready); end
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
      w = q.size() != 0 ? q[0].w : 32'd0;
      n_tests++;
      if (o_count !== 3'(q.size()) || o_valid !== (q.size() != 0) ||
          o_ready !== (!i_rst && q.size() < DEPTH) ||
          {o_funct7, o_rs2, o_rs1, o_funct3, o_rd, o_opcode} !== w ||
          o_pc !== (q.size() != 0 ? q[0].p : 32'd0) ||
          o_fmt !== (q.size() != 0 ? ref_fmt(w) : 3'd7) ||
          o_illegal !== (q.size() != 0 && ref_fmt(w) == 3'd7) ||
          o_imm !== ref_imm(w)) begin
        n_fail++;
        $display("FAIL random[%0d]: got c=%0d v=%b r=%b word=%h pc=%h fmt=%0d ill=%b imm=%h want c=%0d word=%h fmt=%0d imm=%h",
                 i, o_count, o_valid, o_ready, {o_funct7, o_rs2, o_rs1, o_funct3, o_rd, o_opcode}, o_pc,
                 o_fmt, o_illegal, o_imm, q.size(), w, ref_fmt(w), ref_imm(w));
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_full_and_wrap();
    test_flush();
    test_illegal();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_queue_deco.md
# instr_queue_deco

Parametrised instruction register and decoder for the RV32I core, sitting between fetch and the execute/control FSM. It replaces the single write-enabled instruction register with a DEPTH-entry instruction queue that has valid/ready handshakes on both sides and a flush input. The queue head is decoded into register fields, instruction format, illegal flag and a fully sign-extended immediate, so downstream logic no longer reassembles immediate fragments.

## Interface
- XLEN, 32: datapath width of o_imm; 32 only in this revision.
- PC_W, 32: width of the program counter carried with each instruction.
- DEPTH, 4: queue entries; power of two, ≥2.
- clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  fetch presents an instruction.
- o_ready  out  1  queue accepts an instruction this cycle.
- i_instr  in  32  raw instruction word.
- i_pc  in  PC_W  PC of i_instr.
- i_flush  in  1  discard all queued entries (branch/trap redirect).
- o_valid  out  1  head entry is valid.
- i_ready  in  1  consumer takes the head this cycle.
- o_pc  out  PC_W  PC of the head entry.
- o_opcode  out  7; o_funct3  out  3; o_funct7  out  7; o_rd, o_rs1, o_rs2  out  5 each: decoded head fields.
- o_fmt  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- o_imm  out  XLEN  sign-extended immediate for o_fmt; 0 for R and ILL.
- o_illegal  out  1  head opcode is not in the supported map.
- o_count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage: circular buffer of {instr, pc} with write pointer, read pointer and count.
- Push: i_valid && o_ready. Pop: o_valid && i_ready. Both may occur in one cycle; count is then unchanged.
- o_ready = !i_rst && (count < DEPTH). There is no full-bypass: at count==DEPTH a push is refused even if a pop occurs in the same cycle.
- o_valid = (count != 0).
- i_flush: count, rd_ptr and wr_ptr go to 0 on the next edge. Flush overrides a simultaneous push and pop; the pushed word is dropped.
- Pointers wrap modulo DEPTH.
- Decode is combinational from the head entry. When o_valid=0, all decoded outputs and o_pc are 0, o_fmt=ILL and o_illegal=0.
- Opcode map:
  - 0110011 → R
  - 0010011, 0000011, 1100111, 1110011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - Anything else, or instr[1:0]≠11 → ILL with o_illegal=1.
- Immediates (inst = head word):
  - I: sext(inst[31:20])
  - S: sext({inst[31:25], inst[11:7]})
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0})
  - U: {inst[31:12], 12'b0}
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0})
- Field outputs (rd/rs1/rs2/funct) are raw bit slices regardless of format.

## Timing
- Reset (i_rst high at an edge): count=0, pointers=0, o_valid=0, o_count=0. While i_rst is high, o_ready=0. Storage contents are not cleared.
- Reset mid-operation discards all entries exactly like a flush.
- Latency: a word pushed at edge N into an empty queue appears at the head, with o_valid=1 and decoded outputs, after edge N. There is no same-cycle push-to-pop path.
- o_ready depends only on registered count and i_rst, never on i_ready.
- After flush at edge N: o_valid=0 and o_ready=1 after edge N.
- Outputs hold stable while o_valid=1 and i_ready=0.

## Structure
- riscv_pkg holds:
  - Opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL).
  - The fmt encoding constants (FMT_R … FMT_ILL).
- Sub-module imm_gen: combinational, takes instr[31:0] and fmt, returns o_imm[XLEN-1:0]. It is reused by later stages.
- The queue and decode mux stay in instr_queue_deco.

## Test plan
- Push 0x00500093 (addi x1,x0,5), pc=0x100 → next cycle o_valid=1, o_fmt=I, o_rd=1, o_rs1=0, o_imm=0x00000005, o_pc=0x100.
- Push 0xFE000EE3 (beq x0,x0,-4) → o_fmt=B, o_imm=0xFFFFFFFC. Push 0x123452B7 (lui x5) → o_fmt=U, o_rd=5, o_imm=0x12345000.
- Push 5 words with i_ready=0 (DEPTH=4) → o_ready=0 after the 4th, 5th rejected, o_count=4. Then pop/push simultaneously for 8 cycles → order preserved across pointer wrap, o_count stays constant.
- Fill 3 entries, assert i_flush together with i_valid and i_ready → next cycle o_count=0, o_valid=0, and the flushed and pushed words never appear.
- Push 0x00000000 and 0x0000007F → o_illegal=1, o_fmt=7, o_imm=0.
- Assert i_rst for one cycle with 2 entries queued → o_count=0, o_valid=0, o_ready=0 during reset and 1 afterwards.
